// File: rtl/hs_tx_buffered.sv
// hs_tx_buffered
//
// Buffered bundled-data handshake transmitter. Words written from the local
// domain land in a DEPTH-entry circular FIFO. An FSM moves them across a
// req/ack link one at a time, using either 4-phase (return-to-zero) or
// 2-phase (transition) signalling. The asynchronous ack input passes through
// a SYNC_STAGES-deep synchroniser before the FSM uses it.
//
// Handshake contract (link side): data is loaded one edge before req changes
// and stays stable until the next load. A word counts as accepted when the
// synchronised ack matches req: a rising ack in 4-phase mode, or an ack
// toggle in 2-phase mode. snt pulses for that single cycle.
//
// Ports
//   clk      in   single clock, all state on the rising edge
//   reset    in   synchronous, active-low reset
//   vi       in   write strobe; sdata is pushed when high and the FIFO is not full
//   sdata    in   word to send
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds no entries
//   count    out  FIFO occupancy
//   ovf      out  sticky: a write was attempted while full
//   req      out  link request (registered)
//   data     out  link data (registered, bundled with req)
//   ack      in   asynchronous acknowledge from the receiver
//   snt      out  one-cycle pulse: current word accepted by the receiver
//   state_o  out  FSM state for observation (0 IDLE, 1 SETUP, 2 WAIT_HI/WAIT, 3 WAIT_LO)
module hs_tx_buffered #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit PHASE4      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vi,
    input  logic [DATA_W-1:0]        sdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     req,
    output logic [DATA_W-1:0]        data,
    input  logic                     ack,
    output logic                     snt,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);

    // In 2-phase mode WAIT_HI serves as the single WAIT state and WAIT_LO
    // is never entered.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q;
    logic                   req_q, req_d;
    logic [DATA_W-1:0]      data_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_dly_q;

    logic ack_s, ack_rise, ack_tgl;
    logic wr_en, load;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign req   = req_q;
    assign data  = data_q;
    assign state_o = state_q;

    // Writes are blocked by full even when a pop happens in the same cycle.
    assign wr_en = vi & ~full;

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign ack_rise = ack_s & ~ack_dly_q;
    assign ack_tgl  = ack_s ^ ack_dly_q;

    assign count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load};

    // Next-state, request level, load and snt.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        load    = 1'b0;
        snt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = PHASE4 ? 1'b1 : ~req_q;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (PHASE4) begin
                    if (ack_rise) begin
                        req_d   = 1'b0;
                        snt     = 1'b1;
                        state_d = WAIT_LO;
                    end
                end else if (ack_tgl) begin
                    // In WAIT the only legal ack change brings ack_s level
                    // with req, so a toggle marks completion.
                    snt = 1'b1;
                    if (!empty) begin
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    if (!empty) begin
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage is not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            req_q     <= 1'b0;
            data_q    <= '0;
            sync_q    <= '0;
            ack_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            count_q   <= count_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ack};
            ack_dly_q <= ack_s;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (vi && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_tx_buffered.sv
module tb_hs_tx_buffered;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: 4-phase, 2 sync stages ----------------
    logic          a_vi = 1'b0;
    logic [DW-1:0] a_sdata = '0;
    logic          a_ack;
    logic          a_man_ack = 1'b0;
    logic          a_rsp_ack = 1'b0;
    logic          a_auto = 1'b0;
    logic          a_full, a_empty, a_ovf, a_req, a_snt;
    logic [CW-1:0] a_count;
    logic [DW-1:0] a_data;
    logic [1:0]    a_state;
    assign a_ack = a_auto ? a_rsp_ack : a_man_ack;

    hs_tx_buffered #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .PHASE4(1'b1)) u_a (
        .clk(clk), .reset(rst_n), .vi(a_vi), .sdata(a_sdata),
        .full(a_full), .empty(a_empty), .count(a_count), .ovf(a_ovf),
        .req(a_req), .data(a_data), .ack(a_ack), .snt(a_snt), .state_o(a_state)
    );

    // ---------------- DUT B: 2-phase, 2 sync stages ----------------
    logic          b_vi = 1'b0;
    logic [DW-1:0] b_sdata = '0;
    logic          b_ack = 1'b0;
    logic          b_auto = 1'b0;
    logic          b_fixed = 1'b1;
    logic          b_full, b_empty, b_ovf, b_req, b_snt;
    logic [CW-1:0] b_count;
    logic [DW-1:0] b_data;
    logic [1:0]    b_state;

    hs_tx_buffered #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .PHASE4(1'b0)) u_b (
        .clk(clk), .reset(rst_n), .vi(b_vi), .sdata(b_sdata),
        .full(b_full), .empty(b_empty), .count(b_count), .ovf(b_ovf),
        .req(b_req), .data(b_data), .ack(b_ack), .snt(b_snt), .state_o(b_state)
    );

    // ---------------- DUT C: 4-phase, 3 sync stages ----------------
    logic          c_vi = 1'b0;
    logic [DW-1:0] c_sdata = '0;
    logic          c_ack = 1'b0;
    logic          c_full, c_empty, c_ovf, c_req, c_snt;
    logic [CW-1:0] c_count;
    logic [DW-1:0] c_data;
    logic [1:0]    c_state;

    hs_tx_buffered #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(3), .PHASE4(1'b1)) u_c (
        .clk(clk), .reset(rst_n), .vi(c_vi), .sdata(c_sdata),
        .full(c_full), .empty(c_empty), .count(c_count), .ovf(c_ovf),
        .req(c_req), .data(c_data), .ack(c_ack), .snt(c_snt), .state_o(c_state)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboards: words the receiver must see, in order ----------------
    logic [DW-1:0] a_exp_q[$];
    logic [DW-1:0] b_exp_q[$];
    logic [DW-1:0] c_exp_q[$];
    int a_snt_cnt = 0;
    int b_snt_cnt = 0;
    int c_snt_cnt = 0;
    int b_tgl_cnt = 0;
    logic b_req_prev = 1'b0;

    function automatic int qsize(input int which);
        case (which)
            0:       return a_exp_q.size();
            1:       return b_exp_q.size();
            default: return c_exp_q.size();
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_snt) begin
            logic [DW-1:0] e;
            a_snt_cnt++;
            chk("a_snt_has_word", 32'(a_exp_q.size() != 0), 32'd1);
            if (a_exp_q.size() != 0) begin
                e = a_exp_q.pop_front();
                chk("a_word", 32'(a_data), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_snt) begin
            logic [DW-1:0] e;
            b_snt_cnt++;
            chk("b_snt_has_word", 32'(b_exp_q.size() != 0), 32'd1);
            if (b_exp_q.size() != 0) begin
                e = b_exp_q.pop_front();
                chk("b_word", 32'(b_data), 32'(e));
            end
        end
        if (b_req !== b_req_prev) b_tgl_cnt++;
        b_req_prev = b_req;
    end

    always @(negedge clk) begin
        if (rst_n && c_snt) begin
            logic [DW-1:0] e;
            c_snt_cnt++;
            chk("c_snt_has_word", 32'(c_exp_q.size() != 0), 32'd1);
            if (c_exp_q.size() != 0) begin
                e = c_exp_q.pop_front();
                chk("c_word", 32'(c_data), 32'(e));
            end
        end
    end

    // ---------------- receivers: ack follows req level after a delay ----------------
    initial forever begin
        @(negedge clk);
        if (a_auto && (a_req !== a_rsp_ack)) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (a_auto) a_rsp_ack = a_req;
        end
    end

    initial forever begin
        @(negedge clk);
        if (b_auto && (b_req !== b_ack)) begin
            repeat (b_fixed ? 2 : $urandom_range(0, 4)) @(negedge clk);
            if (b_auto) b_ack = b_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic a_write(input logic [DW-1:0] w);
        a_vi = 1'b1;
        a_sdata = w;
        tick(1);
        a_vi = 1'b0;
    endtask

    // Random writes that never exceed the FIFO: occupancy is bounded by
    // words pushed minus words the receiver has accepted.
    task automatic random_words(input int which, input int nwords);
        int sent;
        int guard;
        logic go;
        logic [DW-1:0] w;
        sent = 0;
        guard = 0;
        while (sent < nwords && guard < 4000) begin
            guard++;
            go = (qsize(which) < DEPTH) && ($urandom_range(0, 2) != 0);
            w = DW'($urandom);
            if (which == 0) begin
                a_vi = go;
                a_sdata = w;
                if (go) a_exp_q.push_back(w);
            end else begin
                b_vi = go;
                b_sdata = w;
                if (go) b_exp_q.push_back(w);
            end
            if (go) sent++;
            tick(1);
        end
        a_vi = 1'b0;
        b_vi = 1'b0;
        chk($sformatf("rand%0d_sent", which), 32'(sent), 32'(nwords));
    endtask

    task automatic drain(input int which, input int max_cyc);
        int n;
        n = 0;
        while (qsize(which) != 0 && n < max_cyc) begin
            tick(1);
            n++;
        end
        chk($sformatf("drain%0d_left", which), 32'(qsize(which)), 32'd0);
        tick(12);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] ow [6];
        int exp_cnt [6];
        int base;

        exp_cnt = '{1, 1, 2, 3, 4, 4};

        // Reset
        tick(2);
        chk("rst_req",   32'(a_req),   32'd0);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_snt",   32'(a_snt),   32'd0);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_b_req", 32'(b_req),   32'd0);
        chk("rst_c_empty", 32'(c_empty), 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Single word, 4-phase
        a_exp_q.push_back(8'hA5);
        a_write(8'hA5);
        chk("sw_empty_after_write", 32'(a_empty), 32'd0);
        chk("sw_count_after_write", 32'(a_count), 32'd1);
        tick(1);
        chk("sw_data_loaded", 32'(a_data), 32'hA5);
        chk("sw_req_before",  32'(a_req),  32'd0);
        chk("sw_empty_load",  32'(a_empty), 32'd1);
        tick(1);
        chk("sw_req_rise", 32'(a_req), 32'd1);
        tick(2);
        a_man_ack = 1'b1;
        tick(1);
        chk("sw_snt_A",   32'(a_snt), 32'd0);
        chk("sw_req_A",   32'(a_req), 32'd1);
        tick(1);
        chk("sw_snt_A1",  32'(a_snt), 32'd1);
        chk("sw_req_A1",  32'(a_req), 32'd1);
        chk("sw_empty_A1", 32'(a_empty), 32'd1);
        tick(1);
        chk("sw_req_fall", 32'(a_req), 32'd0);
        chk("sw_snt_A2",   32'(a_snt), 32'd0);
        tick(2);
        a_man_ack = 1'b0;
        tick(4);
        chk("sw_idle",     32'(a_state),   32'd0);
        chk("sw_snt_count", 32'(a_snt_cnt), 32'd1);

        // Overflow with stalled receiver
        for (int i = 0; i < 6; i++) ow[i] = DW'($urandom);
        for (int i = 0; i < 6; i++) begin
            a_vi = 1'b1;
            a_sdata = ow[i];
            if (i < 5) a_exp_q.push_back(ow[i]);
            tick(1);
            chk($sformatf("ovf_count_%0d", i), 32'(a_count), 32'(exp_cnt[i]));
            chk($sformatf("ovf_full_%0d", i),  32'(a_full),  32'(i >= 4));
            chk($sformatf("ovf_flag_%0d", i),  32'(a_ovf),   32'(i == 5));
            if (i == 1) chk("ovf_first_loaded", 32'(a_data), 32'(ow[0]));
        end
        a_vi = 1'b0;
        base = a_snt_cnt;
        a_auto = 1'b1;
        drain(0, 600);
        chk("ovf_snt_pulses", 32'(a_snt_cnt - base), 32'd5);
        chk("ovf_sticky",     32'(a_ovf),   32'd1);
        chk("ovf_empty_end",  32'(a_empty), 32'd1);
        a_auto = 1'b0;

        // Reset mid-handshake with three words queued
        for (int i = 0; i < 4; i++) a_write(DW'($urandom));
        chk("mid_req_high",  32'(a_req),   32'd1);
        chk("mid_count",     32'(a_count), 32'd3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_rst_req",   32'(a_req),   32'd0);
        chk("mid_rst_data",  32'(a_data),  32'd0);
        chk("mid_rst_count", 32'(a_count), 32'd0);
        chk("mid_rst_empty", 32'(a_empty), 32'd1);
        chk("mid_rst_snt",   32'(a_snt),   32'd0);
        chk("mid_rst_ovf",   32'(a_ovf),   32'd0);
        tick(1);
        base = a_snt_cnt;
        a_auto = 1'b1;
        a_exp_q.push_back(8'h3C);
        a_write(8'h3C);
        drain(0, 200);
        chk("mid_post_snt", 32'(a_snt_cnt - base), 32'd1);
        a_auto = 1'b0;

        // Simultaneous write and pop, then randomized traffic across wraps
        base = a_snt_cnt;
        ow[0] = DW'($urandom);
        ow[1] = DW'($urandom);
        ow[2] = DW'($urandom);
        ow[3] = DW'($urandom);
        a_exp_q.push_back(ow[0]);
        a_write(ow[0]);
        tick(2);
        a_exp_q.push_back(ow[1]);
        a_write(ow[1]);
        a_exp_q.push_back(ow[2]);
        a_write(ow[2]);
        chk("sim_count_pre", 32'(a_count), 32'd2);
        a_man_ack = 1'b1;
        tick(3);
        chk("sim_wait_lo_req", 32'(a_req), 32'd0);
        a_man_ack = 1'b0;
        tick(2);
        a_vi = 1'b1;
        a_sdata = ow[3];
        a_exp_q.push_back(ow[3]);
        tick(1);
        a_vi = 1'b0;
        chk("sim_count_kept", 32'(a_count), 32'd2);
        chk("sim_no_ovf",     32'(a_ovf),   32'd0);
        chk("sim_loaded",     32'(a_data),  32'(ow[1]));
        a_auto = 1'b1;
        random_words(0, 7);
        drain(0, 600);
        chk("sim_snt_total", 32'(a_snt_cnt - base), 32'd11);
        random_words(0, 24);
        drain(0, 1200);
        chk("rand_a_snt_total", 32'(a_snt_cnt - base), 32'd35);
        chk("rand_a_no_ovf",    32'(a_ovf),   32'd0);
        chk("rand_a_empty",     32'(a_empty), 32'd1);
        a_auto = 1'b0;

        // 2-phase
        b_fixed = 1'b1;
        b_auto = 1'b1;
        b_exp_q.push_back(8'h11);
        b_exp_q.push_back(8'h22);
        b_exp_q.push_back(8'h33);
        b_vi = 1'b1;
        b_sdata = 8'h11; tick(1);
        b_sdata = 8'h22; tick(1);
        b_sdata = 8'h33; tick(1);
        b_vi = 1'b0;
        drain(1, 400);
        chk("p2_toggles",  32'(b_tgl_cnt), 32'd3);
        chk("p2_req_end",  32'(b_req),     32'd1);
        chk("p2_snt",      32'(b_snt_cnt), 32'd3);
        b_fixed = 1'b0;
        random_words(1, 24);
        drain(1, 1200);
        chk("rand_b_snt",   32'(b_snt_cnt), 32'd27);
        chk("rand_b_tgl",   32'(b_tgl_cnt), 32'd27);
        chk("rand_b_ovf",   32'(b_ovf),     32'd0);
        chk("rand_b_empty", 32'(b_empty),   32'd1);
        b_auto = 1'b0;

        // Deeper synchroniser
        c_exp_q.push_back(8'h5A);
        c_vi = 1'b1;
        c_sdata = 8'h5A;
        tick(1);
        c_vi = 1'b0;
        tick(1);
        chk("s3_data", 32'(c_data), 32'h5A);
        tick(1);
        chk("s3_req_rise", 32'(c_req), 32'd1);
        c_ack = 1'b1;
        tick(1);
        chk("s3_snt_A",  32'(c_snt), 32'd0);
        tick(1);
        chk("s3_snt_A1", 32'(c_snt), 32'd0);
        tick(1);
        chk("s3_snt_A2", 32'(c_snt), 32'd1);
        chk("s3_req_A2", 32'(c_req), 32'd1);
        tick(1);
        chk("s3_req_fall", 32'(c_req), 32'd0);
        chk("s3_snt_A3",   32'(c_snt), 32'd0);
        c_ack = 1'b0;
        tick(8);
        chk("s3_idle",  32'(c_state),   32'd0);
        chk("s3_count", 32'(c_snt_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_tx_buffered.md
# hs_tx_buffered

Parametrised bundled-data handshake transmitter: the next-generation transmit side of the two-flop-synchronised req/ack link. It accepts words from the local domain into a DEPTH-entry FIFO and drives them across the link one at a time. The protocol is selectable as 4-phase (return-to-zero) or 2-phase (transition signalling). The number of ack synchroniser stages is configurable. The block reports sent words, FIFO occupancy and overflow.

## Interface
- DATA_W, 8, width of data word
- DEPTH, 4, FIFO entries; power of 2, >= 2
- SYNC_STAGES, 2, flops in ack synchroniser; >= 2
- PHASE4, 1, 1 = 4-phase RZ protocol, 0 = 2-phase NRZ protocol
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- vi  in  1  write strobe; sdata pushed when high and not full
- sdata  in  DATA_W  word to send
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: a write was attempted while full
- req  out  1  link request (registered)
- data  out  DATA_W  link data (registered, bundled with req)
- ack  in  1  asynchronous acknowledge from receiver
- snt  out  1  one-cycle pulse: current word accepted by receiver

## Operation
- **Reset.** While reset=0 at an edge, the block clears all state. Resulting outputs: req=0, data=0, snt=0, full=0, empty=1, count=0, ovf=0. The synchroniser chain and the delay flop are cleared and the FSM returns to IDLE.
- **Reset mid-transfer.** A reset during a transfer abandons the word in flight and all queued words. The receiver must be reset in the same cycle.
- **FIFO.**
  - Circular buffer with $clog2(DEPTH)-bit read/write pointers that wrap naturally.
  - A write occurs when vi=1 and full=0.
  - vi=1 with full=1 drops the word and sets ovf. ovf clears only on reset.
  - Write and pop in the same cycle: both happen and count is unchanged.
  - full=1 blocks writes even when a pop occurs in that cycle.
- **Ack synchroniser.** ack passes through SYNC_STAGES flops to give ack_s. One further flop gives ack_d. Define ack_rise = ack_s & ~ack_d and ack_tgl = ack_s ^ ack_d.
- **Load.** On a load, the block sets data <= FIFO head and pops the FIFO in the same edge. data changes only on a load, so it is stable whenever req is active.
- **FSM, PHASE4=1.**
  - IDLE: if !empty, load and go to SETUP.
  - SETUP: req <= 1 and go to WAIT_HI.
  - WAIT_HI: on ack_rise, req <= 0, snt=1 and go to WAIT_LO.
  - WAIT_LO: when ack_s=0, go to SETUP with a load if !empty, otherwise go to IDLE.
- **FSM, PHASE4=0.**
  - IDLE: if !empty, load and go to SETUP.
  - SETUP: req <= ~req and go to WAIT.
  - WAIT: when ack_s == req (equivalently on ack_tgl), snt=1. Then go to SETUP with a load if !empty, otherwise go to IDLE.
- **snt.** Combinational from the FSM state and the ack_rise/ack_tgl term, high for exactly one cycle per word.
- **Unexpected ack.** Ack transitions in IDLE or SETUP are protocol errors. They are ignored apart from updating the synchroniser.

## Timing
- **Write to req.** vi is sampled at edge E0. empty falls after E0. The load happens at E1 and req changes at E2, giving 2 cycles.
- **Ack to FSM.** An ack change sampled at edge A makes ack_s change after edge A+SYNC_STAGES-1. snt is high during the following cycle. The FSM transitions, and req falls in 4-phase mode, at edge A+SYNC_STAGES.
- **Back-to-back, 4-phase.** After ack_s falls in WAIT_LO, the next req rises 2 edges later.
- **Back-to-back, 2-phase.** After completion is detected, the next req toggle follows 2 edges later.
- **Outputs.** full, empty and count reflect the registered pointers: they update on the edge after a write or pop.

## Test plan
- **Single word, 4-phase.** DEPTH=4, SYNC_STAGES=2, PHASE4=1. Write 0xA5, then responder sets ack=1 3 cycles after req rises and clears it 3 cycles after req falls. Required: data=0xA5 one cycle before req rises; req falls 2 edges after ack is sampled high; one snt pulse; empty=1 throughout the handshake.
- **Overflow.** Responder stalled (ack=0), write 6 words back-to-back. Required: word 1 is loaded to data; count reaches 4 and full=1; word 6 is dropped and ovf=1. Releasing the responder then yields exactly words 1-5 in order with 5 snt pulses.
- **2-phase mode.** PHASE4=0, write 0x11, 0x22, 0x33, with responder mirroring req level after 2 cycles. Required: req toggles 3 times (0→1→0→1); data order 0x11, 0x22, 0x33; 3 snt pulses; no return-to-zero phase.
- **Simultaneous write and pop.** count=2, with vi=1 on the load edge. Required: count stays 2, no ovf, FIFO order preserved across pointer wrap after 10 words.
- **Reset mid-handshake.** Assert reset=0 in WAIT_HI with 3 words queued. Required: after that edge req=0, data=0, count=0, empty=1, snt=0, ovf=0; a post-reset write completes normally.
- **Deeper synchroniser.** SYNC_STAGES=3, 4-phase, ack raised at edge A. Required: snt in the cycle after edge A+2; req falls at edge A+3.
